stock_code_table_dp: RTL and testbench

Parametrised, dual-port stock-code table for the output-port-lookup path. Port A is the host/register read-write port. Port B is a read-only lookup port for the order-matching pipeline. After every reset or soft clear, an internal sequencer fills the whole table with a known value. Other features: write-first behaviour on both ports, same-cycle A-write to B-read forwarding, and optional per-entry parity.

---
 rtl/stock_code_table_dp_if.sv | 33 +++
 rtl/stock_code_table_dp.sv | 159 +++++++++++++++
 tb/tb_stock_code_table_dp.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stock_code_table_dp_if.sv
// rtl/stock_code_table_dp_if.sv - port A / port B request-response bundle for stock_code_table_dp
//
// Purpose : groups the host read-write port (A) and the lookup port (B).
// Modports: master drives requests and takes results; slave is the table side.
//   a_req/a_we/a_addr/a_din -> table ; a_dout/a_ack/a_perr <- table
//   b_req/b_addr            -> table ; b_dout/b_valid/b_perr <- table
interface stock_code_table_dp_if #(
  parameter int DATA_WIDTH = 70,
  parameter int ADDR_WIDTH = 9
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_ack;
  logic                  a_perr;
  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;
  logic                  b_perr;

  modport master (
    output a_req, a_we, a_addr, a_din, b_req, b_addr,
    input  a_dout, a_ack, a_perr, b_dout, b_valid, b_perr
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din, b_req, b_addr,
    output a_dout, a_ack, a_perr, b_dout, b_valid, b_perr
  );
endinterface

// File: rtl/stock_code_table_dp.sv
// rtl/stock_code_table_dp.sv - dual-port stock-code table with clear sequencer
//
// Purpose : DEPTH-entry table. Port A is host read-write (latency 1, write-first),
//           port B is a read-only lookup (latency 2). After reset or clear the
//           sequencer writes INIT_VALUE to every entry before accepting requests.
// Ports   : axis_aclk, axis_resetn (async, active low), clear (restart pulse),
//           ready (table in RUN), bus (stock_code_table_dp_if.slave, ports A/B).
// Option  : STOCK_CODE_TABLE_PARITY_EN adds one even-parity bit per entry and
//           drives a_perr/b_perr; without it both are tied low.
module stock_code_table_dp #(
  parameter int                    DATA_WIDTH = 70,
  parameter int                    ADDR_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  clear,
  output logic                  ready,
  stock_code_table_dp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef STOCK_CODE_TABLE_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  logic [MEM_W-1:0]      mem [DEPTH];

  logic                  run_ok;
  logic                  a_wr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MEM_W-1:0]      a_rd_word, b_rd_word;
  logic                  a_rd_perr, b_rd_perr;
  logic                  b_fwd;

  logic [DATA_WIDTH-1:0] a_dout_q;
  logic                  a_ack_q, a_perr_q;
  logic                  b1_valid, b1_perr;
  logic [DATA_WIDTH-1:0] b1_data;
  logic [DATA_WIDTH-1:0] b_dout_q;
  logic                  b_valid_q, b_perr_q;

  // Sequencer state register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sequencer next state: one entry per cycle, wrap to 0 on entering RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = S_CLEAR;
      cnt_nxt   = '0;
    end else if (state == S_CLEAR) begin
      cnt_nxt = cnt + ADDR_WIDTH'(1);
      if (cnt == {ADDR_WIDTH{1'b1}}) begin
        state_nxt = S_RUN;
      end
    end
  end

  assign ready = (state == S_RUN);
  // A clear pulse takes precedence over any request presented in the same cycle.
  assign run_ok = ready & ~clear;
  assign a_wr   = run_ok & bus.a_req & bus.a_we;

  // Single write port shared between the sequencer and port A
  always_comb begin
    wr_en   = a_wr;
    wr_addr = bus.a_addr;
    wr_data = bus.a_din;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = INIT_VALUE;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
`ifdef STOCK_CODE_TABLE_PARITY_EN
      mem[wr_addr] <= {^wr_data, wr_data};
`else
      mem[wr_addr] <= wr_data;
`endif
    end
  end

  assign a_rd_word = mem[bus.a_addr];
  assign b_rd_word = mem[bus.b_addr];

`ifdef STOCK_CODE_TABLE_PARITY_EN
  assign a_rd_perr = (^a_rd_word[DATA_WIDTH-1:0]) != a_rd_word[DATA_WIDTH];
  assign b_rd_perr = (^b_rd_word[DATA_WIDTH-1:0]) != b_rd_word[DATA_WIDTH];
`else
  assign a_rd_perr = 1'b0;
  assign b_rd_perr = 1'b0;
`endif

  // Same-cycle A write to the B lookup address: B sees the new data
  assign b_fwd = a_wr & (bus.a_addr == bus.b_addr);

  // Port A: write-first, a_dout holds when idle
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      a_dout_q <= '0;
      a_ack_q  <= 1'b0;
      a_perr_q <= 1'b0;
    end else begin
      a_ack_q  <= run_ok & bus.a_req;
      a_perr_q <= run_ok & bus.a_req & ~bus.a_we & a_rd_perr;
      if (run_ok & bus.a_req) begin
        a_dout_q <= bus.a_we ? bus.a_din : a_rd_word[DATA_WIDTH-1:0];
      end
    end
  end

  // Port B: stage 1 captures the RAM word, stage 2 is the output register.
  // A clear arriving while a lookup sits in stage 1 kills it before it emerges.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      b1_valid  <= 1'b0;
      b1_perr   <= 1'b0;
      b1_data   <= '0;
      b_valid_q <= 1'b0;
      b_perr_q  <= 1'b0;
      b_dout_q  <= '0;
    end else begin
      b1_valid  <= run_ok & bus.b_req;
      b1_perr   <= ~b_fwd & b_rd_perr;
      b1_data   <= b_fwd ? bus.a_din : b_rd_word[DATA_WIDTH-1:0];
      b_valid_q <= b1_valid & ~clear;
      b_perr_q  <= b1_valid & ~clear & b1_perr;
      b_dout_q  <= b1_data;
    end
  end

  assign bus.a_dout  = a_dout_q;
  assign bus.a_ack   = a_ack_q;
  assign bus.a_perr  = a_perr_q;
  assign bus.b_dout  = b_dout_q;
  assign bus.b_valid = b_valid_q;
  assign bus.b_perr  = b_perr_q;
endmodule

// File: tb/tb_stock_code_table_dp.sv
// tb/tb_stock_code_table_dp.sv - self-checking bench for stock_code_table_dp
module tb_stock_code_table_dp;
  localparam int DW    = 70;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  localparam logic [DW-1:0] D_BIG  = 70'h3F_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] D_ZERO = '0;
  localparam logic [DW-1:0] D_0A   = 70'h0A;
  localparam logic [DW-1:0] D_15   = 70'h15;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic clear  = 1'b0;
  logic ready;

  stock_code_table_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  stock_code_table_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .axis_aclk   (clk),
    .axis_resetn (resetn),
    .clear       (clear),
    .ready       (ready),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: table contents, corrupted-entry flags, cycles since
  // the last reset/clear, expected a_dout and the queue of pending B results.
  typedef struct {
    logic [DW-1:0] data;
    bit            perr;
    int            due;
  } bexp_t;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_flip [DEPTH];
  int            m_since;
  logic [DW-1:0] m_adout;
  bexp_t         m_q [$];

  typedef struct {
    bit            a_req;
    bit            a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    bit            b_req;
    logic [AW-1:0] b_addr;
    bit            chk_a;
    logic [DW-1:0] exp_a;
    bit            chk_b;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(input bit ar, input bit aw, input int aa, input logic [DW-1:0] ad,
                              input bit br, input int ba, input bit ca, input logic [DW-1:0] ea,
                              input bit cb, input logic [DW-1:0] eb);
    vec_t v;
    v.a_req  = ar;
    v.a_we   = aw;
    v.a_addr = AW'(aa);
    v.a_din  = ad;
    v.b_req  = br;
    v.b_addr = AW'(ba);
    v.chk_a  = ca;
    v.exp_a  = ea;
    v.chk_b  = cb;
    v.exp_b  = eb;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Whole table is rewritten after reset/clear, so the model can zero it at once.
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = D_ZERO;
      m_flip[i] = 1'b0;
    end
    m_since = 0;
    m_q.delete();
  endtask

  task automatic idle();
    bus.a_req  = 1'b0;
    bus.a_we   = 1'b0;
    bus.a_addr = '0;
    bus.a_din  = '0;
    bus.b_req  = 1'b0;
    bus.b_addr = '0;
  endtask

  // One clock: update the model from the inputs now on the bus, take the
  // edge, then compare every output against the model.
  task automatic step();
    bit    run;
    bit    exp_ack;
    bit    exp_aperr;
    bit    fwd;
    bexp_t e;
    run       = (m_since >= DEPTH);
    exp_ack   = 1'b0;
    exp_aperr = 1'b0;
    if (clear) begin
      model_clear();
    end else if (run) begin
      if (bus.b_req) begin
        fwd    = bus.a_req && bus.a_we && (bus.a_addr == bus.b_addr);
        e.data = fwd ? bus.a_din : m_mem[bus.b_addr];
        e.perr = fwd ? 1'b0 : m_flip[bus.b_addr];
        e.due  = cyc + 2;
        m_q.push_back(e);
      end
      if (bus.a_req) begin
        exp_ack = 1'b1;
        if (bus.a_we) begin
          m_adout             = bus.a_din;
          m_mem[bus.a_addr]  = bus.a_din;
          m_flip[bus.a_addr] = 1'b0;
        end else begin
          m_adout   = m_mem[bus.a_addr];
          exp_aperr = m_flip[bus.a_addr];
        end
      end
    end else begin
      m_since++;
    end
    cyc++;
    @(posedge clk);
    #1;
    chk1("ready", ready, m_since >= DEPTH);
    chk1("a_ack", bus.a_ack, exp_ack);
    chkd("a_dout", bus.a_dout, m_adout);
    chk1("a_perr", bus.a_perr, exp_aperr);
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      chk1("b_valid", bus.b_valid, 1'b1);
      chkd("b_dout", bus.b_dout, m_q[0].data);
      chk1("b_perr", bus.b_perr, m_q[0].perr);
      void'(m_q.pop_front());
    end else begin
      chk1("b_valid", bus.b_valid, 1'b0);
      chk1("b_perr", bus.b_perr, 1'b0);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 600) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_outputs();
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_a_ack", bus.a_ack, 1'b0);
    chkd("rst_a_dout", bus.a_dout, D_ZERO);
    chk1("rst_a_perr", bus.a_perr, 1'b0);
    chk1("rst_b_valid", bus.b_valid, 1'b0);
    chkd("rst_b_dout", bus.b_dout, D_ZERO);
    chk1("rst_b_perr", bus.b_perr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [95:0]   r;

    idle();
    model_clear();
    m_adout = D_ZERO;

    // Power-on reset and first fill
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    wait_ready(n);
    chki("first_ready_latency", n, DEPTH);

    // Directed vectors from the table
    vt[0] = mk(1, 0, 0,   D_ZERO, 0, 0, 1, D_ZERO, 0, D_ZERO);
    vt[1] = mk(1, 0, 255, D_ZERO, 0, 0, 1, D_ZERO, 0, D_ZERO);
    vt[2] = mk(1, 0, 511, D_ZERO, 0, 0, 1, D_ZERO, 0, D_ZERO);
    vt[3] = mk(1, 1, 7,   D_BIG,  0, 0, 1, D_BIG,  0, D_ZERO);
    vt[4] = mk(0, 0, 0,   D_ZERO, 1, 7, 0, D_ZERO, 1, D_BIG);
    vt[5] = mk(1, 0, 7,   D_ZERO, 0, 0, 1, D_BIG,  0, D_ZERO);
    vt[6] = mk(1, 1, 3,   D_0A,   0, 0, 1, D_0A,   0, D_ZERO);
    vt[7] = mk(1, 1, 3,   D_15,   1, 3, 1, D_15,   1, D_15);
    vt[8] = mk(0, 0, 0,   D_ZERO, 1, 3, 0, D_ZERO, 1, D_15);
    for (int i = 0; i < 9; i++) begin
      bus.a_req  = vt[i].a_req;
      bus.a_we   = vt[i].a_we;
      bus.a_addr = vt[i].a_addr;
      bus.a_din  = vt[i].a_din;
      bus.b_req  = vt[i].b_req;
      bus.b_addr = vt[i].b_addr;
      step();
      if (vt[i].chk_a) begin
        chk1("vec_a_ack", bus.a_ack, 1'b1);
        chkd("vec_a_dout", bus.a_dout, vt[i].exp_a);
      end
      idle();
      step();
      if (vt[i].chk_b) begin
        chk1("vec_b_valid", bus.b_valid, 1'b1);
        chkd("vec_b_dout", bus.b_dout, vt[i].exp_b);
      end
      step();
    end

    // A write one cycle after a B read to the same address is not seen by it
    bus.b_req  = 1'b1;
    bus.b_addr = AW'(5);
    step();
    idle();
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b1;
    bus.a_addr = AW'(5);
    bus.a_din  = D_BIG;
    step();
    idle();
    chk1("late_wr_b_valid", bus.b_valid, 1'b1);
    chkd("late_wr_b_dout", bus.b_dout, D_ZERO);
    step();

`ifdef STOCK_CODE_TABLE_PARITY_EN
    // Corrupt one stored bit of entry 9 and read it back on both ports
    dut.mem[9][0] = ~dut.mem[9][0];
    m_mem[9][0]   = ~m_mem[9][0];
    m_flip[9]     = 1'b1;
    bus.a_req  = 1'b1;
    bus.a_addr = AW'(9);
    bus.b_req  = 1'b1;
    bus.b_addr = AW'(9);
    step();
    chk1("par_a_perr", bus.a_perr, 1'b1);
    idle();
    bus.a_req  = 1'b1;
    bus.a_addr = AW'(10);
    step();
    chk1("par_b_perr", bus.b_perr, 1'b1);
    chk1("par_clean_a_perr", bus.a_perr, 1'b0);
    idle();
    step();
`endif

    // Random traffic on a small address window to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      r          = {$urandom(), $urandom(), $urandom()};
      bus.a_req  = ($urandom_range(0, 2) != 0);
      bus.a_we   = $urandom_range(0, 1) == 1;
      bus.a_addr = AW'($urandom_range(0, 15));
      bus.a_din  = r[DW-1:0];
      bus.b_req  = ($urandom_range(0, 2) != 0);
      bus.b_addr = AW'($urandom_range(0, 15));
      step();
    end
    idle();
    step();
    step();
    chki("rand_drain", m_q.size(), 0);

    // Clear in RUN drops an in-flight lookup; clear again at cycle 100 of CLEAR
    bus.b_req  = 1'b1;
    bus.b_addr = AW'(7);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk1("clr_drop_b_valid", bus.b_valid, 1'b0);
    step();
    chk1("clr_drop_b_valid2", bus.b_valid, 1'b0);
    repeat (98) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_addr = AW'(0);
    step();
    idle();
    chk1("clr_no_a_ack", bus.a_ack, 1'b0);
    wait_ready(n);
    chki("clear_ready_latency", n + 1, DEPTH);

    // Reset mid-RUN while B streams
    for (int i = 0; i < 6; i++) begin
      bus.b_req  = 1'b1;
      bus.b_addr = AW'(i);
      step();
    end
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    m_adout = D_ZERO;
    idle();
    @(posedge clk);
    cyc++;
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    wait_ready(n);
    chki("rerun_ready_latency", n, DEPTH);
    bus.a_req  = 1'b1;
    bus.a_addr = AW'(3);
    step();
    idle();
    chkd("post_reset_a_dout", bus.a_dout, D_ZERO);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
